alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_lfsr3.sv | 36 +++
 rtl/alu.sv | 61 ++++++
 tb/tb_alu.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the fault-injection ALU:
//   - fault-site indices into the 12-bit check mask (A, B, C, w1..w9)
//   - LFSR reset / all-zero replacement seed
//   - alu_circuit(): the gate network with per-site stuck-at injection.
//     The golden and faulty copies both come from this one function; the
//     golden copy simply passes an all-zero mask.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int N_SITES = 12;

    localparam int SITE_A  = 0;
    localparam int SITE_B  = 1;
    localparam int SITE_C  = 2;
    localparam int SITE_W1 = 3;
    localparam int SITE_W2 = 4;
    localparam int SITE_W3 = 5;
    localparam int SITE_W4 = 6;
    localparam int SITE_W5 = 7;
    localparam int SITE_W6 = 8;
    localparam int SITE_W7 = 9;
    localparam int SITE_W8 = 10;
    localparam int SITE_W9 = 11;

    localparam logic [2:0] LFSR_RESET = 3'b001;

    typedef logic [N_SITES-1:0] site_mask_t;

    // Replace a net by the stuck-at value when its site is selected.
    function automatic logic pick(input logic sig, input logic sel, input logic val);
        return sel ? val : sig;
    endfunction

    // Each net is overridden before it feeds downstream gates, so a fault on
    // an early net propagates through everything that depends on it.
    function automatic logic alu_circuit(input logic [2:0] p,
                                         input site_mask_t chk,
                                         input logic       val);
        logic a, b, c;
        logic w1, w2, w3, w4, w5, w6, w7, w8, w9;
        a  = pick(p[2],          chk[SITE_A],  val);
        b  = pick(p[1],          chk[SITE_B],  val);
        c  = pick(p[0],          chk[SITE_C],  val);
        w1 = pick(a & b,         chk[SITE_W1], val);
        w2 = pick(b | c,         chk[SITE_W2], val);
        w3 = pick(~c,            chk[SITE_W3], val);
        w4 = pick(w1 ^ w2,       chk[SITE_W4], val);
        w5 = pick(a & w3,        chk[SITE_W5], val);
        w6 = pick(w4 | w5,       chk[SITE_W6], val);
        w7 = pick(~(w2 & w3),    chk[SITE_W7], val);
        w8 = pick(w6 & w7,       chk[SITE_W8], val);
        w9 = pick(w8 ^ a,        chk[SITE_W9], val);
        return w9;
    endfunction

endpackage

// File: rtl/alu_lfsr3.sv
// ---------------------------------------------------------------------------
// alu_lfsr3
// 3-bit maximal-length LFSR used as the self-test pattern source.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, forces q = 001
//   enable - 1: advance one step per edge, 0: load seed
//   seed   - value loaded while enable = 0 (000 is replaced by 001)
//   q      - current LFSR state, never all-zero
// Sequence: 001,010,101,011,111,110,100,001 ...
// ---------------------------------------------------------------------------
module alu_lfsr3
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] seed,
    output logic [2:0] q
);

    // All-zero is the lock-up state of an XOR LFSR, so a zero seed is
    // swapped for the reset value instead of being loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= LFSR_RESET;
        end else if (enable) begin
            q <= {q[1:0], q[2] ^ q[1]};
        end else if (seed == 3'b000) begin
            q <= LFSR_RESET;
        end else begin
            q <= seed;
        end
    end

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Fault-injection demonstrator: a small gate network evaluated twice on the
// same pattern, once with stuck-at faults injected and once fault-free.
// Ports:
//   in     - {A,B,C} direct pattern, also the LFSR seed
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset (clears e, LFSR -> 001)
//   enable - 1: use LFSR patterns, 0: use in directly and load the seed
//   check  - fault-site select mask (bits 0..2 = A,B,C, 3..11 = w1..w9)
//   value  - stuck-at value forced onto every selected site
//   y      - combinational output of the faulty copy
//   e      - registered faulty-vs-golden mismatch flag
// Build option:
//   ALU_STICKY_ERR_EN - when defined, e latches high until reset.
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [2:0]         in,
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_SITES-1:0] check,
    input  logic               value,
    output logic               y,
    output logic               e
);

    logic [2:0] lfsr;
    logic [2:0] pattern;
    logic       y_golden;
    logic       mismatch;

    alu_lfsr3 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .seed   (in),
        .q      (lfsr)
    );

    assign pattern  = enable ? lfsr : in;
    assign y        = alu_circuit(pattern, check, value);
    assign y_golden = alu_circuit(pattern, '0, 1'b0);
    assign mismatch = (y != y_golden);

    // Error flag sampled one cycle after the pattern is applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e <= 1'b0;
        end else begin
`ifdef ALU_STICKY_ERR_EN
            e <= e | mismatch;
`else
            e <= mismatch;
`endif
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Directed self-checking bench for alu. Inputs change just after the falling
// edge; outputs are sampled away from the rising edge.
// ---------------------------------------------------------------------------
module tb_alu;

    logic [2:0]  in_bits;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [11:0] check;
    logic        value;
    logic        y;
    logic        e;

    int checkCount = 0;
    int failCount  = 0;

    alu dut (
        .in     (in_bits),
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .check  (check),
        .value  (value),
        .y      (y),
        .e      (e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic r, input logic en, input logic [2:0] p,
                                 input logic [11:0] chk, input logic val);
        reset   = r;
        enable  = en;
        in_bits = p;
        check   = chk;
        value   = val;
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [2:0] observed,
                               input logic [2:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
        end
    endtask

    // Hand-computed LFSR walk from 001 with B stuck-at-1:
    // faulty y per state, and whether it differs from the golden output.
    logic [2:0] lfsrSeq [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
    logic       faultyY [7] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1};
    logic       mism    [7] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1};

    // Main directed sequence.
    initial begin
        logic expE;
        logic sawErr;

        // Reset with in=100, no faults.
        applyStimulus(1'b1, 1'b0, 3'b100, 12'h000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_e", {2'b00, e}, 3'b000);
        checkOutput("reset_lfsr", dut.lfsr, 3'b001);
        applyStimulus(1'b0, 1'b0, 3'b100, 12'h000, 1'b0);
        checkOutput("nofault_y_100", {2'b00, y}, 3'b000);
        @(negedge clk);
        checkOutput("nofault_e_100", {2'b00, e}, 3'b000);
        checkOutput("seed_load_100", dut.lfsr, 3'b100);

        // B stuck-at-1 on 100: excited.
        applyStimulus(1'b0, 1'b0, 3'b100, 12'h002, 1'b1);
        checkOutput("bsa1_y_100", {2'b00, y}, 3'b001);
        @(negedge clk);
        checkOutput("bsa1_e_100", {2'b00, e}, 3'b001);

        // B stuck-at-1 on 110: not excited.
        applyStimulus(1'b0, 1'b0, 3'b110, 12'h002, 1'b1);
        checkOutput("bsa1_y_110", {2'b00, y}, 3'b001);
        @(negedge clk);
`ifdef ALU_STICKY_ERR_EN
        checkOutput("bsa1_e_110_sticky", {2'b00, e}, 3'b001);
`else
        checkOutput("bsa1_e_110", {2'b00, e}, 3'b000);
`endif

        // Reset with enable held high: enable ignored, e cleared at once.
        applyStimulus(1'b1, 1'b1, 3'b110, 12'h002, 1'b1);
        checkOutput("rst_async_e", {2'b00, e}, 3'b000);
        checkOutput("rst_async_lfsr", dut.lfsr, 3'b001);
        @(negedge clk);
        checkOutput("rst_hold_lfsr", dut.lfsr, 3'b001);

        // Self-test walk with B stuck-at-1.
        applyStimulus(1'b0, 1'b1, 3'b110, 12'h002, 1'b1);
        expE   = 1'b0;
        sawErr = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("walk_lfsr_%0d", k), dut.lfsr, lfsrSeq[k]);
            checkOutput($sformatf("walk_y_%0d", k), {2'b00, y}, {2'b00, faultyY[k]});
            @(negedge clk);
`ifdef ALU_STICKY_ERR_EN
            expE = expE | mism[k];
`else
            expE = mism[k];
`endif
            checkOutput($sformatf("walk_e_%0d", k), {2'b00, e}, {2'b00, expE});
            sawErr = sawErr | e;
        end
        checkOutput("walk_err_seen", {2'b00, sawErr}, 3'b001);
        checkOutput("walk_wrap", dut.lfsr, 3'b001);

        // w9 stuck-at-0 on pattern 001.
        applyStimulus(1'b0, 1'b0, 3'b001, 12'h800, 1'b0);
        checkOutput("w9sa0_y", {2'b00, y}, 3'b000);
        @(negedge clk);
        checkOutput("w9sa0_e", {2'b00, e}, 3'b001);

        // Remove fault, pulse reset, e must stay low for 100 time units.
        applyStimulus(1'b1, 1'b0, 3'b011, 12'h000, 1'b0);
        checkOutput("pulse_e", {2'b00, e}, 3'b000);
        #2;
        applyStimulus(1'b0, 1'b0, 3'b011, 12'h000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("quiet_e_%0d", k), {2'b00, e}, 3'b000);
        end
        checkOutput("seed_load_011", dut.lfsr, 3'b011);

        // Zero seed is replaced by 001.
        applyStimulus(1'b0, 1'b0, 3'b000, 12'h000, 1'b0);
        checkOutput("golden_y_000", {2'b00, y}, 3'b000);
        @(negedge clk);
        checkOutput("zero_seed_lfsr", dut.lfsr, 3'b001);

        // Build up e=1 with lfsr=100, then assert reset mid-cycle.
        applyStimulus(1'b0, 1'b0, 3'b100, 12'h002, 1'b1);
        @(negedge clk);
        checkOutput("pre_mid_e", {2'b00, e}, 3'b001);
        checkOutput("pre_mid_lfsr", dut.lfsr, 3'b100);
        #2;
        applyStimulus(1'b1, 1'b0, 3'b100, 12'h002, 1'b1);
        checkOutput("mid_rst_e", {2'b00, e}, 3'b000);
        checkOutput("mid_rst_lfsr", dut.lfsr, 3'b001);
        checkOutput("mid_rst_y", {2'b00, y}, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
